// File: rtl/stencil_sched_pkg.sv
// Shared types and helpers for the stencil coprocessor AXI burst scheduler.
// Burst length honours the beat limit, the words left and the 4 KB page boundary.
package stencil_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } sched_state_t;

    localparam logic [1:0]  AXI_OKAY   = 2'b00;
    localparam int unsigned PAGE_BYTES = 4096;

    function automatic logic [8:0] burst_len(input logic [31:0] addr,
                                             input logic [31:0] remaining,
                                             input int unsigned max_burst);
        logic [31:0] page_words;
        logic [31:0] len;
        page_words = (PAGE_BYTES - {20'd0, addr[11:0]}) >> 2;
        len = max_burst;
        if (remaining < len) len = remaining;
        if (page_words < len) len = page_words;
        return len[8:0];
    endfunction

endpackage

// File: rtl/stencil_burst_split.sv
// One address channel of the scheduler: splits a job into bursts, gates issue on
// FIFO credit and in-flight limit, and holds ADDR/LEN/VALID until READY.
// With STENCIL_SCHED_PERF_EN defined it also reports a per-cycle stall flag.
module stencil_burst_split
    import stencil_sched_pkg::*;
#(
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter bit          BEAT_RETIRE     = 1'b1,
    parameter int unsigned CW              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 run_i,
    input  logic [31:0]          base_i,
    input  logic [LEN_WIDTH-1:0] words_i,
    input  logic [CW-1:0]        credit_i,
    input  logic                 beat_i,
    input  logic                 retire_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [31:0]          addr_o,
    output logic [7:0]           len_o,
`ifdef STENCIL_SCHED_PERF_EN
    output logic                 stall_o,
`endif
    output logic                 idle_o
);
    localparam int unsigned RW = CW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]          addr_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic                 valid_q;
    logic [8:0]           len_q;
    logic [RW-1:0]        reserved_q, reserved_d;
    logic [OW-1:0]        outstanding_q, outstanding_d;
    logic [8:0]           lens_q [MAX_OUTSTANDING];
    logic [PW-1:0]        head_q, tail_q;
    logic [8:0]           beat_cnt_q;
    logic [8:0]           len_w;
    logic                 hs, credit_ok, slot_ok, has_work, issue, beat_retire, retire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // In beat-retire mode a burst leaves the in-flight count when its last beat lands,
    // so the issued lengths are queued in order; otherwise retire_i (B handshake) does it.
    always_comb begin
        len_w         = burst_len(addr_q, 32'(remaining_q), MAX_BURST);
        hs            = valid_q && ready_i;
        credit_ok     = 32'(credit_i) >= 32'(reserved_q) + 32'(len_w);
        slot_ok       = 32'(outstanding_q) < MAX_OUTSTANDING;
        has_work      = remaining_q != '0;
        issue         = run_i && !valid_q && has_work && credit_ok && slot_ok;
        beat_retire   = beat_i && (outstanding_q != '0) && ((beat_cnt_q + 9'd1) == lens_q[head_q]);
        retire        = BEAT_RETIRE ? beat_retire : (retire_i && (outstanding_q != '0));
        reserved_d    = reserved_q + (hs ? RW'(len_q) : '0);
        if (beat_i && (reserved_d != '0)) reserved_d = reserved_d - 1'b1;
        outstanding_d = outstanding_q + OW'(hs) - OW'(retire);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q        <= '0;
            remaining_q   <= '0;
            valid_q       <= 1'b0;
            len_q         <= '0;
            reserved_q    <= '0;
            outstanding_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            beat_cnt_q    <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) lens_q[i] <= '0;
        end else begin
            if (load_i) begin
                addr_q      <= base_i;
                remaining_q <= words_i;
            end else if (hs) begin
                addr_q      <= addr_q + {21'd0, len_q, 2'b00};
                remaining_q <= remaining_q - LEN_WIDTH'(len_q);
            end
            if (hs) begin
                valid_q <= 1'b0;
            end else if (issue) begin
                valid_q <= 1'b1;
                len_q   <= len_w;
            end
            reserved_q    <= reserved_d;
            outstanding_q <= outstanding_d;
            if (hs) begin
                lens_q[tail_q] <= len_q;
                tail_q         <= ptr_inc(tail_q);
            end
            if (BEAT_RETIRE && beat_i && (outstanding_q != '0)) begin
                if (beat_retire) begin
                    beat_cnt_q <= '0;
                    head_q     <= ptr_inc(head_q);
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign len_o   = (len_q == '0) ? 8'd0 : 8'(len_q - 9'd1);
    assign idle_o  = (remaining_q == '0) && (outstanding_q == '0) && !valid_q;
`ifdef STENCIL_SCHED_PERF_EN
    assign stall_o = run_i && !valid_q && has_work && !(credit_ok && slot_ok);
`endif

endmodule

// File: rtl/stencil_dma_sched.sv
// Burst scheduler for the stencil coprocessor AXI4 FIFO master: job FSM, error flag,
// and one burst splitter per direction. STENCIL_SCHED_PERF_EN adds stall counters.
module stencil_dma_sched
    import stencil_sched_pkg::*;
#(
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] words,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic [CNT_W-1:0]     rd_fifo_free,
    input  logic                 rd_beat,
    input  logic [CNT_W-1:0]     wr_fifo_count,
    input  logic                 wr_beat,
    output logic [31:0]          ARADDR,
    output logic [7:0]           ARLEN,
    output logic                 ARVALID,
    input  logic                 ARREADY,
    output logic [31:0]          AWADDR,
    output logic [7:0]           AWLEN,
    output logic                 AWVALID,
    input  logic                 AWREADY,
    input  logic [1:0]           BRESP,
    input  logic                 BVALID,
`ifdef STENCIL_SCHED_PERF_EN
    output logic [31:0]          rd_stall_cyc,
    output logic [31:0]          wr_stall_cyc,
`endif
    output logic                 BREADY
);
    sched_state_t state_q, state_d;
    logic         err_q;
    logic         load, run, rd_idle, wr_idle, b_hs;

    assign load = start && (state_q == ST_IDLE);
    assign run  = (state_q == ST_RUN);
    assign b_hs = BVALID && BREADY;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = (words == '0) ? ST_FINISH : ST_RUN;
            ST_RUN:    if (wr_idle && rd_idle) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) err_q <= 1'b0;
            else if (b_hs && (BRESP != AXI_OKAY)) err_q <= 1'b1;
        end
    end

    assign busy   = run;
    assign done   = (state_q == ST_FINISH);
    assign err    = err_q;
    assign BREADY = 1'b1;

`ifdef STENCIL_SCHED_PERF_EN
    logic        rd_stall, wr_stall;
    logic [31:0] rd_stall_q, wr_stall_q;
    always_ff @(posedge ACLK) begin
        if (ARESET || load) begin
            rd_stall_q <= '0;
            wr_stall_q <= '0;
        end else begin
            if (rd_stall && (rd_stall_q != '1)) rd_stall_q <= rd_stall_q + 1'b1;
            if (wr_stall && (wr_stall_q != '1)) wr_stall_q <= wr_stall_q + 1'b1;
        end
    end
    assign rd_stall_cyc = rd_stall_q;
    assign wr_stall_cyc = wr_stall_q;
`endif

    stencil_burst_split #(
        .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH), .LEN_WIDTH(LEN_WIDTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING), .BEAT_RETIRE(1'b1), .CW(CNT_W)
    ) u_rd (
        .clk_i(ACLK), .rst_i(ARESET), .load_i(load), .run_i(run),
        .base_i(src_addr), .words_i(words), .credit_i(rd_fifo_free),
        .beat_i(rd_beat), .retire_i(1'b0), .ready_i(ARREADY),
        .valid_o(ARVALID), .addr_o(ARADDR), .len_o(ARLEN),
`ifdef STENCIL_SCHED_PERF_EN
        .stall_o(rd_stall),
`endif
        .idle_o(rd_idle)
    );

    // Write bursts retire on B; the credit here is data already sitting in the output FIFO.
    stencil_burst_split #(
        .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH), .LEN_WIDTH(LEN_WIDTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING), .BEAT_RETIRE(1'b0), .CW(CNT_W)
    ) u_wr (
        .clk_i(ACLK), .rst_i(ARESET), .load_i(load), .run_i(run),
        .base_i(dst_addr), .words_i(words), .credit_i(wr_fifo_count),
        .beat_i(wr_beat), .retire_i(b_hs), .ready_i(AWREADY),
        .valid_o(AWVALID), .addr_o(AWADDR), .len_o(AWLEN),
`ifdef STENCIL_SCHED_PERF_EN
        .stall_o(wr_stall),
`endif
        .idle_o(wr_idle)
    );

endmodule

// File: tb/tb_stencil_dma_sched.sv
// Directed bench for stencil_dma_sched: AXI slave + FIFO model, expected-queue scoreboard.
module tb_stencil_dma_sched;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic [15:0] words = '0;
    logic        busy, done, err;
    logic [6:0]  rd_fifo_free = 7'd64, wr_fifo_count = '0;
    logic        rd_beat = 1'b0, wr_beat = 1'b0;
    logic [31:0] ARADDR, AWADDR;
    logic [7:0]  ARLEN, AWLEN;
    logic        ARVALID, AWVALID, BREADY;
    logic        ARREADY = 1'b1, AWREADY = 1'b1;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0;
`ifdef STENCIL_SCHED_PERF_EN
    logic [31:0] rd_stall_cyc, wr_stall_cyc;
`endif

    stencil_dma_sched dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .words(words), .busy(busy), .done(done), .err(err),
        .rd_fifo_free(rd_fifo_free), .rd_beat(rd_beat), .wr_fifo_count(wr_fifo_count),
        .wr_beat(wr_beat), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID),
        .AWREADY(AWREADY), .BRESP(BRESP), .BVALID(BVALID),
`ifdef STENCIL_SCHED_PERF_EN
        .rd_stall_cyc(rd_stall_cyc), .wr_stall_cyc(wr_stall_cyc),
`endif
        .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_ar_q[$];
    logic [39:0] exp_aw_q[$];
    logic        exp_done_q[$];

    // slave model state
    logic [8:0] r_len_q[$], w_len_q[$];
    logic [1:0] b_pend_q[$];
    int r_left = 0, w_left = 0, fifo_words = 0, b_count = 0, bad_b_index = -1;
    logic w_last_drv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: compare address handshakes and done pulses against the expected queues
    initial begin : monitor
        logic [39:0] e;
        logic        e_err;
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (ARVALID && ARREADY) begin
                    if (exp_ar_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ar_unexpected: got AR 0x%0h len %0d expected none", ARADDR, ARLEN);
                    end else begin
                        e = exp_ar_q.pop_front();
                        check("ar_addr", ARADDR, e[39:8]);
                        check("ar_len", 32'(ARLEN), 32'(e[7:0]));
                    end
                end
                if (AWVALID && AWREADY) begin
                    if (exp_aw_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_unexpected: got AW 0x%0h len %0d expected none", AWADDR, AWLEN);
                    end else begin
                        e = exp_aw_q.pop_front();
                        check("aw_addr", AWADDR, e[39:8]);
                        check("aw_len", 32'(AWLEN), 32'(e[7:0]));
                    end
                end
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got done=1 expected none");
                    end else begin
                        e_err = exp_done_q.pop_front();
                        check("done_err", 32'(err), 32'(e_err));
                    end
                end
            end
        end
    end

    // AXI slave + FIFO model: R beats feed the FIFO, W beats drain it, B after each W burst
    initial begin : slave
        logic       ar_fire, aw_fire;
        logic [7:0] ar_len_s, aw_len_s;
        forever begin
            @(negedge ACLK);
            ar_fire = ARVALID && ARREADY; ar_len_s = ARLEN;
            aw_fire = AWVALID && AWREADY; aw_len_s = AWLEN;
            @(posedge ACLK); #1;
            if (ARESET) begin
                r_len_q.delete(); w_len_q.delete(); b_pend_q.delete();
                r_left = 0; w_left = 0; fifo_words = 0; w_last_drv = 1'b0;
                rd_beat = 1'b0; wr_beat = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
                wr_fifo_count = '0;
            end else begin
                if (rd_beat) fifo_words++;
                if (wr_beat) begin
                    fifo_words--;
                    if (w_last_drv) begin
                        b_pend_q.push_back((b_count == bad_b_index) ? 2'b10 : 2'b00);
                        b_count++;
                    end
                end
                if (ar_fire) r_len_q.push_back(9'(ar_len_s) + 9'd1);
                if (aw_fire) w_len_q.push_back(9'(aw_len_s) + 9'd1);
                rd_beat = 1'b0;
                if (r_left == 0 && r_len_q.size() > 0) r_left = int'(r_len_q.pop_front());
                if (r_left > 0) begin rd_beat = 1'b1; r_left--; end
                wr_beat = 1'b0; w_last_drv = 1'b0;
                if (w_left == 0 && w_len_q.size() > 0) w_left = int'(w_len_q.pop_front());
                if (w_left > 0 && fifo_words > 0) begin
                    wr_beat = 1'b1; w_left--; w_last_drv = (w_left == 0);
                end
                BVALID = 1'b0; BRESP = 2'b00;
                if (b_pend_q.size() > 0) begin BVALID = 1'b1; BRESP = b_pend_q.pop_front(); end
                wr_fifo_count = 7'(fifo_words);
            end
        end
    end

    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] w);
        @(posedge ACLK); #1;
        b_count = 0;
        src_addr = s; dst_addr = d; words = w; start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge ACLK);
            seen = done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic expect_job1(input logic e_err);
        exp_ar_q.push_back({32'h8000, 8'd15});
        exp_ar_q.push_back({32'h8040, 8'd15});
        exp_aw_q.push_back({32'h4000, 8'd15});
        exp_aw_q.push_back({32'h4040, 8'd15});
        exp_done_q.push_back(e_err);
    endtask

    initial begin : main
        bit seen_ar;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_arvalid", 32'(ARVALID), 32'd0);
        check("rst_awvalid", 32'(AWVALID), 32'd0);
        check("rst_bready", 32'(BREADY), 32'd1);
        check("rst_araddr", ARADDR, 32'd0);
        check("rst_awaddr", AWADDR, 32'd0);
        check("rst_arlen", 32'(ARLEN), 32'd0);
        check("rst_awlen", 32'(AWLEN), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        // basic 32-word copy
        expect_job1(1'b0);
        run_job(32'h8000, 32'h4000, 16'h20);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(1000);

        // read straddling a 4 KB page
        exp_ar_q.push_back({32'h0FF8, 8'd1});
        exp_ar_q.push_back({32'h1000, 8'd5});
        exp_aw_q.push_back({32'h2000, 8'd7});
        exp_done_q.push_back(1'b0);
        run_job(32'h0FF8, 32'h2000, 16'd8);
        wait_done(1000);

        // insufficient read credit holds AR back
        rd_fifo_free = 7'd10;
        exp_ar_q.push_back({32'h0000, 8'd15});
        exp_ar_q.push_back({32'h0040, 8'd15});
        exp_aw_q.push_back({32'h3000, 8'd15});
        exp_aw_q.push_back({32'h3040, 8'd15});
        exp_done_q.push_back(1'b0);
        run_job(32'h0000, 32'h3000, 16'd32);
        seen_ar = 1'b0;
        repeat (10) begin
            @(negedge ACLK);
            if (ARVALID) seen_ar = 1'b1;
        end
        check("ar_held_low", 32'(seen_ar), 32'd0);
        @(posedge ACLK); #1;
        rd_fifo_free = 7'd16;
        @(negedge ACLK);
        @(negedge ACLK);
        check("ar_after_credit", 32'(ARVALID), 32'd1);
        wait_done(1000);
        rd_fifo_free = 7'd64;

        // second B carries SLVERR
        bad_b_index = 1;
        expect_job1(1'b1);
        run_job(32'h8000, 32'h4000, 16'h20);
        wait_done(1000);
        bad_b_index = -1;
        @(negedge ACLK);
        check("err_sticky", 32'(err), 32'd1);

        // zero-word job: done exactly one cycle after start, err cleared
        exp_done_q.push_back(1'b0);
        @(posedge ACLK); #1;
        words = '0; start = 1'b1;
        @(negedge ACLK);
        check("zero_done_early", 32'(done), 32'd0);
        @(posedge ACLK); #1;
        start = 1'b0;
        @(negedge ACLK);
        check("zero_done", 32'(done), 32'd1);
        check("zero_err_cleared", 32'(err), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        @(negedge ACLK);
        check("zero_done_once", 32'(done), 32'd0);

        // reset one cycle after the first AR handshake
        exp_ar_q.push_back({32'h8000, 8'd15});
        run_job(32'h8000, 32'h4000, 16'h20);
        seen_ar = 1'b0;
        for (int i = 0; i < 50 && !seen_ar; i++) begin
            @(negedge ACLK);
            seen_ar = ARVALID && ARREADY;
        end
        check("rst_mid_first_ar", 32'(seen_ar), 32'd1);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        check("rst_mid_arvalid", 32'(ARVALID), 32'd0);
        check("rst_mid_awvalid", 32'(AWVALID), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        check("rst_mid_ar_q", 32'(exp_ar_q.size()), 32'd0);
        expect_job1(1'b0);
        run_job(32'h8000, 32'h4000, 16'h20);
        wait_done(1000);

        repeat (5) @(posedge ACLK);
        check("end_ar_q", 32'(exp_ar_q.size()), 32'd0);
        check("end_aw_q", 32'(exp_aw_q.size()), 32'd0);
        check("end_done_q", 32'(exp_done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
